// File: rtl/rec_seq_gen_pkg.sv
// Shared types and elaboration helpers for the order-K recurrence generator.
package rec_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  localparam int ORDER_MIN = 2;
  localparam int ORDER_MAX = 8;

  function automatic bit order_ok(input int k);
    return (k >= ORDER_MIN) && (k <= ORDER_MAX);
  endfunction

  function automatic int sum_w(input int w, input int k);
    return w + $clog2(k);
  endfunction

endpackage

// File: rtl/rec_seq_gen_if.sv
// Valid/ready term link carrying one recurrence term plus end-of-run flag.
interface rec_seq_gen_if #(
  parameter int WIDTH = 32
);

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  logic             last;

  modport master (
    output valid,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    output ready
  );

endinterface

// File: rtl/rec_seq_gen_sum_tree.sv
// Combinational unsigned sum of the K window terms, widened so
// no carry is lost.
module rec_sum_tree
  import rec_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ORDER = 2,
  parameter int SUM_W = sum_w(WIDTH, ORDER)
) (
  input  logic [ORDER-1:0][WIDTH-1:0] terms,
  output logic [SUM_W-1:0]            sum
);

  always_comb begin
    sum = '0;
    for (int i = 0; i < ORDER; i++) begin
      sum = sum + SUM_W'(terms[i]);
    end
  end

endmodule

// File: rtl/rec_seq_gen.sv
// Order-K linear recurrence term generator on a valid/ready link.
// Optional REC_SEQ_OVF_HALT_EN: end the run before any wrapped term.
module rec_seq_gen
  import rec_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ORDER = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ORDER*WIDTH-1:0] seed_i,
  input  logic [CNT_W-1:0]       len_i,
  rec_seq_gen_if.master          out,
  output logic                   busy,
  output logic                   done,
  output logic                   ovf
);

  localparam int SUM_W = sum_w(WIDTH, ORDER);

  if (!order_ok(ORDER)) begin : g_order_chk
    $error("rec_seq_gen: ORDER must be in 2..8");
  end

  state_t                      state;
  logic [ORDER-1:0][WIDTH-1:0] w;
  logic [ORDER-1:0]            ovf_w;
  logic [CNT_W-1:0]            rem;
  logic [SUM_W-1:0]            sum;
  logic                        hs;
  logic                        new_ovf;
  logic                        ovf_hit;

  rec_sum_tree #(
    .WIDTH (WIDTH),
    .ORDER (ORDER),
    .SUM_W (SUM_W)
  ) u_sum (
    .terms (w),
    .sum   (sum)
  );

  // taint sticks to every term derived from a wrapped one
  assign new_ovf = (|sum[SUM_W-1:WIDTH]) | (|ovf_w);

  assign hs        = out.valid & out.ready;
  assign out.valid = (state == RUN);
  assign out.data  = w[0];
  assign busy      = (state == RUN);
  assign done      = (state == FIN);

`ifdef REC_SEQ_OVF_HALT_EN
  assign out.last = (rem == CNT_W'(1)) | ovf_w[1];
  assign ovf_hit  = ovf_w[1];
`else
  assign out.last = (rem == CNT_W'(1));
  assign ovf_hit  = ovf_w[0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      w     <= '0;
      ovf_w <= '0;
      rem   <= '0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            w     <= seed_i;
            ovf_w <= '0;
            rem   <= len_i;
            ovf   <= 1'b0;
            state <= (len_i == '0) ? FIN : RUN;
          end
        end
        RUN: begin
          if (hs) begin
            for (int i = 0; i < ORDER-1; i++) begin
              w[i]     <= w[i+1];
              ovf_w[i] <= ovf_w[i+1];
            end
            w[ORDER-1]     <= sum[WIDTH-1:0];
            ovf_w[ORDER-1] <= new_ovf;
            rem            <= rem - CNT_W'(1);
            if (ovf_hit) ovf <= 1'b1;
          end
          // abort beats a simultaneous final handshake
          if (abort) state <= IDLE;
          else if (hs && out.last) state <= FIN;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rec_seq_gen.sv
// Scoreboard bench for rec_seq_gen: three instances (K=2, K=3, 8-bit K=2).
// Honors REC_SEQ_OVF_HALT_EN for the overflow expectations.
module tb_rec_seq_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  start = '0;
  logic        abort = 1'b0;
  logic [15:0] len = '0;
  logic [63:0] seed_a = '0;
  logic [95:0] seed_b = '0;
  logic [15:0] seed_c = '0;
  logic        fix_rdy = 1'b1;
  logic        rnd_rdy = 1'b1;
  logic        rnd_en = 1'b0;
  logic        rdy;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic        ovf_a, ovf_b, ovf_c;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int st_cyc = 0;
  int last_cyc = 0;
  int sel = 0;

  logic [32:0] q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rnd_rdy <= 1'($urandom_range(0, 1));

  assign rdy = rnd_en ? rnd_rdy : fix_rdy;

  rec_seq_gen_if #(.WIDTH(32)) ia ();
  rec_seq_gen_if #(.WIDTH(32)) ib ();
  rec_seq_gen_if #(.WIDTH(8))  ic ();

  assign ia.ready = rdy;
  assign ib.ready = rdy;
  assign ic.ready = rdy;

  rec_seq_gen #(.WIDTH(32), .ORDER(2), .CNT_W(16)) u_a (
    .clk (clk), .rst (rst), .start (start[0]), .abort (abort),
    .seed_i (seed_a), .len_i (len), .out (ia),
    .busy (busy_a), .done (done_a), .ovf (ovf_a)
  );

  rec_seq_gen #(.WIDTH(32), .ORDER(3), .CNT_W(16)) u_b (
    .clk (clk), .rst (rst), .start (start[1]), .abort (abort),
    .seed_i (seed_b), .len_i (len), .out (ib),
    .busy (busy_b), .done (done_b), .ovf (ovf_b)
  );

  rec_seq_gen #(.WIDTH(8), .ORDER(2), .CNT_W(16)) u_c (
    .clk (clk), .rst (rst), .start (start[2]), .abort (abort),
    .seed_i (seed_c), .len_i (len), .out (ic),
    .busy (busy_c), .done (done_c), .ovf (ovf_c)
  );

  logic        m_valid, m_last, m_busy, m_done, m_ovf;
  logic [31:0] m_data;

  assign m_valid = (sel == 0) ? ia.valid : (sel == 1) ? ib.valid : ic.valid;
  assign m_last  = (sel == 0) ? ia.last  : (sel == 1) ? ib.last  : ic.last;
  assign m_data  = (sel == 0) ? ia.data  : (sel == 1) ? ib.data  : {24'd0, ic.data};
  assign m_busy  = (sel == 0) ? busy_a   : (sel == 1) ? busy_b   : busy_c;
  assign m_done  = (sel == 0) ? done_a   : (sel == 1) ? done_b   : done_c;
  assign m_ovf   = (sel == 0) ? ovf_a    : (sel == 1) ? ovf_b    : ovf_c;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // monitor: pops the scoreboard on each handshake, checks stall stability
  logic        stall_prev = 1'b0;
  logic [31:0] hold_d;
  logic        hold_l;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 64'(m_valid), 64'd1);
        chk("stall_data", 64'(m_data), 64'(hold_d));
        chk("stall_last", 64'(m_last), 64'(hold_l));
      end
      stall_prev = m_valid && !rdy && !abort;
      hold_d = m_data;
      hold_l = m_last;
      if (m_valid && rdy) begin
        if (q.size() == 0) begin
          chk("unexpected_term", 64'(m_data), 64'hdead);
        end else begin
          logic [32:0] e;
          e = q.pop_front();
          chk("data", 64'(m_data), 64'(e[31:0]));
          chk("last", 64'(m_last), 64'(e[32]));
        end
        if (m_last) last_cyc = cyc;
      end
    end
  end

  // independent reference: full-precision terms, wrap + taint per term
  task automatic push_model(input int k, input int wd, input longint unsigned sd[8],
                            input int n, output bit eovf);
    longint unsigned t[$];
    bit              tn[$];
    longint unsigned mask;
    longint unsigned s;
    bit              tt;
    bit              lst;
    mask = (64'd1 << wd) - 1;
    for (int i = 0; i < k; i++) begin
      t.push_back(sd[i]);
      tn.push_back(1'b0);
    end
    for (int i = k; i <= n; i++) begin
      s = 0;
      tt = 0;
      for (int j = 1; j <= k; j++) begin
        s += t[i-j];
        tt |= tn[i-j];
      end
      t.push_back(s & mask);
      tn.push_back(tt | (s > mask));
    end
    eovf = 0;
    for (int i = 0; i < n; i++) begin
`ifdef REC_SEQ_OVF_HALT_EN
      lst = (i == n-1) || tn[i+1];
      q.push_back({lst, t[i][31:0]});
      if (lst) begin
        eovf = tn[i+1];
        break;
      end
`else
      lst = (i == n-1);
      q.push_back({lst, t[i][31:0]});
      eovf |= tn[i];
`endif
    end
  endtask

  task automatic go(input int s, input logic [15:0] n);
    sel = s;
    len = n;
    start = '0;
    start[s] = 1'b1;
    @(posedge clk);
    #1 start = '0;
    st_cyc = cyc;
  endtask

  task automatic wait_done(input string tag, input int budget, input bit zlen, input bit eovf);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!m_done && k < budget);
    chk({tag, "_done"}, 64'(m_done), 64'd1);
    chk({tag, "_done_cyc"}, 64'(cyc), zlen ? 64'(st_cyc) : 64'(last_cyc + 1));
    chk({tag, "_ovf"}, 64'(m_ovf), 64'(eovf));
    chk({tag, "_drain"}, 64'(q.size()), 64'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(m_done), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bit eo;
    int dn;
    seed_a = {32'd1, 32'd0};
    seed_b = {32'd1, 32'd0, 32'd0};
    seed_c = {8'd1, 8'd1};
    repeat (3) @(posedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst_valid", 64'(m_valid), 64'd0);
      chk("rst_data", 64'(m_data), 64'd0);
      chk("rst_last", 64'(m_last), 64'd0);
      chk("rst_busy", 64'(m_busy), 64'd0);
      chk("rst_done", 64'(m_done), 64'd0);
      chk("rst_ovf", 64'(m_ovf), 64'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // fibonacci, full throughput
    push_model(2, 32, '{0, 1, 0, 0, 0, 0, 0, 0}, 10, eo);
    go(0, 16'd10);
    chk("lat_valid", 64'(m_valid), 64'd1);
    chk("lat_busy", 64'(m_busy), 64'd1);
    wait_done("fib", 40, 1'b0, eo);

    // tribonacci
    push_model(3, 32, '{0, 0, 1, 0, 0, 0, 0, 0}, 8, eo);
    go(1, 16'd8);
    wait_done("trib", 40, 1'b0, eo);

    // fibonacci under random backpressure
    rnd_en = 1'b1;
    push_model(2, 32, '{0, 1, 0, 0, 0, 0, 0, 0}, 10, eo);
    go(0, 16'd10);
    wait_done("fib_bp", 400, 1'b0, eo);
    rnd_en = 1'b0;

    // zero-length run
    go(0, 16'd0);
    chk("zlen_valid", 64'(m_valid), 64'd0);
    wait_done("zlen", 5, 1'b1, 1'b0);

    // start during a run must not relatch
    push_model(2, 32, '{0, 1, 0, 0, 0, 0, 0, 0}, 10, eo);
    go(0, 16'd10);
    repeat (2) @(posedge clk);
    #1;
    seed_a = {32'd7, 32'd9};
    len = 16'd3;
    start[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1 start = '0;
    seed_a = {32'd1, 32'd0};
    wait_done("restart", 40, 1'b0, eo);

    // abort after three handshakes
    push_model(2, 32, '{0, 1, 0, 0, 0, 0, 0, 0}, 10, eo);
    while (q.size() > 3) void'(q.pop_back());
    go(0, 16'd10);
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    fix_rdy = 1'b0;
    @(posedge clk);
    #1 abort = 1'b0;
    dn = 0;
    @(negedge clk);
    chk("abort_valid", 64'(m_valid), 64'd0);
    chk("abort_busy", 64'(m_busy), 64'd0);
    dn |= int'(m_done);
    repeat (3) begin
      @(negedge clk);
      dn |= int'(m_done);
    end
    chk("abort_no_done", 64'(dn), 64'd0);
    chk("abort_drain", 64'(q.size()), 64'd0);
    fix_rdy = 1'b1;

    // 8-bit overflow
    push_model(2, 8, '{1, 1, 0, 0, 0, 0, 0, 0}, 16, eo);
    go(2, 16'd16);
    chk("ovf8_first", 64'(m_data), 64'd1);
    wait_done("ovf8", 60, 1'b0, eo);

    // asynchronous reset mid-run
    push_model(2, 32, '{0, 1, 0, 0, 0, 0, 0, 0}, 10, eo);
    while (q.size() > 2) void'(q.pop_back());
    go(0, 16'd10);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mrst_valid", 64'(m_valid), 64'd0);
    chk("mrst_data", 64'(m_data), 64'd0);
    chk("mrst_busy", 64'(m_busy), 64'd0);
    chk("mrst_done", 64'(m_done), 64'd0);
    chk("mrst_ovf_c", 64'(ovf_c), 64'd0);
    chk("mrst_drain", 64'(q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst_idle_done", 64'(m_done), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
